// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: default widths and pointer compare helpers
// that work for any pointer width, so other FIFO variants can reuse them.
package fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_ADDR_WIDTH = 4;

  // Pointers are ADDR_WIDTH+1 bits wide; the extra MSB is a wrap bit that
  // distinguishes a full FIFO from an empty one when the address bits match.
  // Callers zero-extend their pointers to 32 bits and pass the address width.
  function automatic logic ptr_full(input logic [31:0] wp,
                                    input logic [31:0] rp,
                                    input int          aw);
    logic [31:0] ptr_mask;
    logic [31:0] wrap_bit;
    ptr_mask = (32'd1 << (aw + 1)) - 32'd1;
    wrap_bit = 32'd1 << aw;
    return ((wp ^ rp) & ptr_mask) == wrap_bit;
  endfunction

  function automatic logic ptr_empty(input logic [31:0] wp,
                                     input logic [31:0] rp,
                                     input int          aw);
    logic [31:0] ptr_mask;
    ptr_mask = (32'd1 << (aw + 1)) - 32'd1;
    return ((wp ^ rp) & ptr_mask) == 32'd0;
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Simple dual-port storage for sync_fifo: one write port and one read
// port with a registered output. Only the output register is reset;
// the array itself keeps whatever it held.
module sync_fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

`ifdef VENDORRAM

  vendor_dpram_macro #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_vendor_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .re    (re),
    .raddr (raddr),
    .rdata (rdata)
  );

`else

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Write port: store the word whenever the top level accepts a write.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read port: register the addressed word on a read, otherwise hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

`endif

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO: pointer bookkeeping, status flags and error pulses
// around the sync_fifo_mem storage array.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH      = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH      = DEFAULT_ADDR_WIDTH,
  parameter int ALMOST_FULL_TH  = 12,
  parameter int ALMOST_EMPTY_TH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [ADDR_WIDTH:0] AF_TH = ALMOST_FULL_TH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AE_TH = ALMOST_EMPTY_TH[ADDR_WIDTH:0];

  logic [ADDR_WIDTH:0] wr_ptr;
  logic [ADDR_WIDTH:0] rd_ptr;
  logic                wr_acc;
  logic                rd_acc;

  // Flags come only from the registered pointers, so a same-cycle read
  // never frees room for a write and a same-cycle write never feeds a read.
  always_comb begin
    count        = wr_ptr - rd_ptr;
    full         = ptr_full(32'(wr_ptr), 32'(rd_ptr), ADDR_WIDTH);
    empty        = ptr_empty(32'(wr_ptr), 32'(rd_ptr), ADDR_WIDTH);
    almost_full  = (count >= AF_TH);
    almost_empty = (count <= AE_TH);
    wr_acc       = wr_en && !full;
    rd_acc       = rd_en && !empty;
  end

  // Advance pointers on accepted requests and raise one-cycle status pulses;
  // pointers wrap naturally through their wrap bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      rd_valid  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      rd_valid  <= rd_acc;
      overflow  <= wr_en && full;
      underflow <= rd_en && empty;
    end
  end

  sync_fifo_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_acc),
    .waddr (wr_ptr[ADDR_WIDTH-1:0]),
    .wdata (wr_data),
    .re    (rd_acc),
    .raddr (rd_ptr[ADDR_WIDTH-1:0]),
    .rdata (rd_data)
  );

endmodule

// File: tb/tb_sync_fifo.sv
// Directed plus randomized bench for sync_fifo, checked against a
// queue-based model of FIFO behaviour.
module tb_sync_fifo;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int AF_TH = 12;
  localparam int AE_TH = 2;

  logic          clk;
  logic          rst_n;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          rd_en;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic [AW:0]   count;
  logic          overflow;
  logic          underflow;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [DW-1:0] model_q[$];
  logic [DW-1:0] exp_rd_data  = '0;
  logic          exp_rd_valid = 1'b0;
  logic          exp_overflow = 1'b0;
  logic          exp_underflow = 1'b0;

  sync_fifo #(
    .DATA_WIDTH     (DW),
    .ADDR_WIDTH     (AW),
    .ALMOST_FULL_TH (AF_TH),
    .ALMOST_EMPTY_TH(AE_TH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Compare every DUT output against the model's view of the FIFO.
  task automatic checkOutput(input string tag);
    int n;
    n = model_q.size();
    chk({tag, ".count"},        32'(count),        32'(n));
    chk({tag, ".full"},         32'(full),         32'(n == DEPTH));
    chk({tag, ".empty"},        32'(empty),        32'(n == 0));
    chk({tag, ".almost_full"},  32'(almost_full),  32'(n >= AF_TH));
    chk({tag, ".almost_empty"}, 32'(almost_empty), 32'(n <= AE_TH));
    chk({tag, ".rd_valid"},     32'(rd_valid),     32'(exp_rd_valid));
    chk({tag, ".rd_data"},      32'(rd_data),      32'(exp_rd_data));
    chk({tag, ".overflow"},     32'(overflow),     32'(exp_overflow));
    chk({tag, ".underflow"},    32'(underflow),    32'(exp_underflow));
  endtask

  // One clock of stimulus: drive on the falling edge, update the model on
  // the rising edge using the pre-edge occupancy, then check shortly after.
  task automatic applyStimulus(input logic rst, input logic wr, input logic [DW-1:0] d,
                               input logic rd, input string tag);
    bit was_full;
    bit was_empty;
    @(negedge clk);
    rst_n   = rst;
    wr_en   = wr;
    wr_data = d;
    rd_en   = rd;
    @(posedge clk);
    if (!rst) begin
      model_q.delete();
      exp_rd_data   = '0;
      exp_rd_valid  = 1'b0;
      exp_overflow  = 1'b0;
      exp_underflow = 1'b0;
    end else begin
      was_full      = (model_q.size() == DEPTH);
      was_empty     = (model_q.size() == 0);
      exp_overflow  = wr && was_full;
      exp_underflow = rd && was_empty;
      exp_rd_valid  = rd && !was_empty;
      if (rd && !was_empty) exp_rd_data = model_q.pop_front();
      if (wr && !was_full) model_q.push_back(d);
    end
    #1;
    checkOutput(tag);
  endtask

  initial begin
    rst_n   = 1'b0;
    wr_en   = 1'b0;
    wr_data = '0;
    rd_en   = 1'b0;

    // Reset state
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, "reset0");
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, "reset1");

    // Fill to full, then one write too many
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 1'b1, 8'(i), 1'b0, "fill");
    applyStimulus(1'b1, 1'b1, 8'hAA, 1'b0, "overflow17");
    chk("overflow17.direct", 32'(overflow), 32'd1);

    // Drain to empty, then one read too many
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, "drain");
    chk("drain.last_word", 32'(rd_data), 32'h0F);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, "underflow17");
    chk("underflow17.held", 32'(rd_data), 32'h0F);

    // Steady state at count 8 with simultaneous traffic across the wrap
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b1, 8'(8'h20 + i), 1'b0, "half");
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b1, 8'(8'h40 + i), 1'b1, "both8");
    chk("both8.count", 32'(count), 32'd8);
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, "drain8");

    // Empty with simultaneous write and read: read rejected
    applyStimulus(1'b1, 1'b1, 8'h5A, 1'b1, "empty_both");
    chk("empty_both.count", 32'(count), 32'd1);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, "empty_both_read");
    chk("empty_both_read.data", 32'(rd_data), 32'h5A);

    // Full with simultaneous write and read: write rejected
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 1'b1, 8'(8'h80 + i), 1'b0, "refill");
    applyStimulus(1'b1, 1'b1, 8'hEE, 1'b1, "full_both");
    chk("full_both.count", 32'(count), 32'd15);

    // Reset mid-operation with wr_en held
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, "preset");
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 8'(8'hC0 + i), 1'b0, "five");
    applyStimulus(1'b0, 1'b1, 8'hCF, 1'b0, "midreset");
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, "stale_read");
    chk("stale_read.underflow", 32'(underflow), 32'd1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 199) != 0), 1'($urandom_range(0, 1)),
                    8'($urandom), 1'($urandom_range(0, 1)), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
